door_ctrl: RTL and testbench
============================

DOOR_CTRL -- requirements
Module: door_ctrl

Interface
REQ-001 Parameter TRAVEL_CYCLES, default 8: number of clk cycles for a full door open or close stroke (range 2..255).
REQ-002 Parameter MAX_REOPEN, default 3: obstruction reopens allowed per closed-to-closed cycle before nudge (range 1..15).
REQ-003 clk  input  1  single system clock, all state updates on posedge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 arrive  input  1  car has stopped at a floor; request to open.
REQ-006 open_btn  input  1  door-open button, level.
REQ-007 close_btn  input  1  door-close button, level.
REQ-008 obstruct  input  1  door-edge obstruction sensor, level.
REQ-009 moving  input  1  car in motion; inhibits opening.
REQ-010 timeout  input  1  door-open timeout, driven by the timeout block from estado.
REQ-011 estado  output  2  door state: 00 CLOSED, 01 OPEN, 10 OPENING, 11 CLOSING.
REQ-012 motor_open / motor_close  output  1 each  door motor drive.
REQ-013 door_closed  output  1  high only in CLOSED; travel permit.
REQ-014 buzzer  output  1  nudge warning.

Function
REQ-015 Moore FSM, states CLOSED/OPENING/OPEN/CLOSING; all outputs decoded from registered state only.
REQ-016 Travel counter counts 0..TRAVEL_CYCLES-1; width = clog2(TRAVEL_CYCLES).
REQ-017 CLOSED: (arrive | open_btn) & !moving -> OPENING, counter = 0; moving=1 holds CLOSED regardless of other inputs.
REQ-018 OPENING: motor_open=1, counter +1 per cycle; at counter == TRAVEL_CYCLES-1 -> OPEN; OPENING lasts exactly TRAVEL_CYCLES cycles from 0.
REQ-019 OPEN: (timeout | close_btn) & !obstruct & !open_btn -> CLOSING, counter = 0; otherwise hold OPEN.
REQ-020 CLOSING: motor_close=1, counter +1 per cycle; at counter == TRAVEL_CYCLES-1 -> CLOSED.
REQ-021 CLOSING with obstruct or open_btn (non-nudge) -> OPENING, counter = TRAVEL_CYCLES-1-counter (reverse from current position).
REQ-022 reopen_cnt increments on each obstruct-caused reversal, saturates at MAX_REOPEN, clears on entry to CLOSED.
REQ-023 Re-entering OPEN after a reversal restarts the external timeout, since estado leaves 01.
REQ-024 motor_open and motor_close never both 1.
REQ-025 Simultaneous: timeout & obstruct in OPEN -> hold OPEN; close_btn & open_btn -> open_btn wins.

Reset
REQ-026 rst_n low -> immediately CLOSED: estado=00, motors=0, door_closed=1, buzzer=0, counter=0, reopen_cnt=0, including mid-stroke.
REQ-027 First transition allowed on the first posedge clk after rst_n rises.

Configuration
REQ-028 Macro DOOR_NUDGE_EN defined: in CLOSING with reopen_cnt == MAX_REOPEN, obstruct and open_btn are ignored, buzzer=1 for the whole stroke, close completes in TRAVEL_CYCLES cycles.
REQ-029 Macro DOOR_NUDGE_EN undefined: obstruct always reverses; buzzer tied 0; reopen_cnt still maintained.

Structure
REQ-030 Package door_pkg: state encoding constants (ST_CLOSED=2'b00, ST_OPEN=2'b01, ST_OPENING=2'b10, ST_CLOSING=2'b11) and parameter defaults; ST_OPEN SHALL stay 2'b01 to match the timeout block.
REQ-031 Sub-module door_travel_cnt: loadable up-counter with load value, enable and terminal-count flag; FSM in door_ctrl.

Verification (TRAVEL_CYCLES=8, MAX_REOPEN=3)
REQ-032 Reset release, arrive pulse at cycle 0 -> estado=10, motor_open=1 cycles 1..8; estado=01 from cycle 9.
REQ-033 OPEN, timeout=1 -> estado=11 next cycle for 8 cycles, then 00, door_closed=1.
REQ-034 obstruct on 3rd CLOSING cycle (counter=2) -> OPENING with counter=5, estado=01 after 3 cycles, reopen_cnt=1.
REQ-035 Obstruct held through 4 close attempts -> DOOR_NUDGE_EN: 4th CLOSING has buzzer=1, reaches 00 after 8 cycles; no macro: reverses each time, buzzer=0.
REQ-036 moving=1 with open_btn=1 in CLOSED -> estado stays 00; rst_n low mid-CLOSING -> estado=00 before next clk edge.

Source files
------------

// File: rtl/door_pkg.sv
// Shared door state encoding and parameter defaults for door_ctrl.
// ST_OPEN is fixed at 2'b01 because the external timeout block decodes it.
package door_pkg;

  typedef enum logic [1:0] {
    ST_CLOSED  = 2'b00,
    ST_OPEN    = 2'b01,
    ST_OPENING = 2'b10,
    ST_CLOSING = 2'b11
  } state_t;

  localparam int DEF_TRAVEL_CYCLES = 8;
  localparam int DEF_MAX_REOPEN    = 3;
  localparam int REOPEN_W          = 4;

endpackage

// File: rtl/door_travel_cnt.sv
// Loadable stroke-position up-counter with a terminal-count flag.
module door_travel_cnt #(
  parameter int             W      = 3,
  parameter logic [W-1:0]   TC_VAL = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  // Load has priority so a reversal can reposition mid-stroke.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en)   cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/door_ctrl.sv
// Elevator door controller: Moore FSM driving the door motors.
// Build option DOOR_NUDGE_EN: after MAX_REOPEN obstruction reversals the door closes with buzzer on.
module door_ctrl
  import door_pkg::*;
#(
  parameter int TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
  parameter int MAX_REOPEN    = DEF_MAX_REOPEN
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arrive,
  input  logic       open_btn,
  input  logic       close_btn,
  input  logic       obstruct,
  input  logic       moving,
  input  logic       timeout,
  output logic [1:0] estado,
  output logic       motor_open,
  output logic       motor_close,
  output logic       door_closed,
  output logic       buzzer
);

  localparam int                  CW   = $clog2(TRAVEL_CYCLES);
  localparam logic [CW-1:0]       LAST = CW'(TRAVEL_CYCLES - 1);
  localparam logic [REOPEN_W-1:0] RMAX = REOPEN_W'(MAX_REOPEN);

  state_t              state, nxt;
  logic [REOPEN_W-1:0] reopen_cnt, reopen_nxt;
  logic                cnt_load, cnt_en, tc, nudge;
  logic [CW-1:0]       cnt_ld_val, cnt;

  door_travel_cnt #(.W(CW), .TC_VAL(LAST)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_ld_val),
    .en       (cnt_en),
    .cnt      (cnt),
    .tc       (tc)
  );

`ifdef DOOR_NUDGE_EN
  assign nudge  = (reopen_cnt == RMAX);
  assign buzzer = (state == ST_CLOSING) && nudge;
`else
  assign nudge  = 1'b0;
  assign buzzer = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_CLOSED;
      reopen_cnt <= '0;
    end else begin
      state      <= nxt;
      reopen_cnt <= reopen_nxt;
    end
  end

  always_comb begin
    nxt        = state;
    reopen_nxt = reopen_cnt;
    cnt_load   = 1'b0;
    cnt_ld_val = '0;
    cnt_en     = 1'b0;
    case (state)
      ST_CLOSED: begin
        if ((arrive || open_btn) && !moving) begin
          nxt      = ST_OPENING;
          cnt_load = 1'b1;
        end
      end
      ST_OPENING: begin
        if (tc) nxt = ST_OPEN;
        else    cnt_en = 1'b1;
      end
      ST_OPEN: begin
        if ((timeout || close_btn) && !obstruct && !open_btn) begin
          nxt      = ST_CLOSING;
          cnt_load = 1'b1;
        end
      end
      ST_CLOSING: begin
        // Reversal reopens from the current position, mirrored into the open stroke.
        if (!nudge && (obstruct || open_btn)) begin
          nxt        = ST_OPENING;
          cnt_load   = 1'b1;
          cnt_ld_val = LAST - cnt;
          if (obstruct && reopen_cnt != RMAX) reopen_nxt = reopen_cnt + 1'b1;
        end else if (tc) begin
          nxt        = ST_CLOSED;
          reopen_nxt = '0;
        end else begin
          cnt_en = 1'b1;
        end
      end
    endcase
  end

  assign estado      = state;
  assign motor_open  = (state == ST_OPENING);
  assign motor_close = (state == ST_CLOSING);
  assign door_closed = (state == ST_CLOSED);

endmodule

// File: tb/tb_door_ctrl.sv
// Directed self-checking bench for door_ctrl at TRAVEL_CYCLES=8, MAX_REOPEN=3.
module tb_door_ctrl;

`ifdef DOOR_NUDGE_EN
  localparam bit NUDGE = 1'b1;
`else
  localparam bit NUDGE = 1'b0;
`endif

  logic       clk, rst_n;
  logic       arrive, open_btn, close_btn, obstruct, moving, timeout;
  logic [1:0] estado;
  logic       motor_open, motor_close, door_closed, buzzer;
  int         checks = 0;
  int         passes = 0;

  door_ctrl #(.TRAVEL_CYCLES(8), .MAX_REOPEN(3)) dut (
    .clk(clk), .rst_n(rst_n), .arrive(arrive), .open_btn(open_btn),
    .close_btn(close_btn), .obstruct(obstruct), .moving(moving), .timeout(timeout),
    .estado(estado), .motor_open(motor_open), .motor_close(motor_close),
    .door_closed(door_closed), .buzzer(buzzer)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic open_door();
    arrive = 1'b1;
    tick();
    arrive = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    rst_n = 1'b0; arrive = 0; open_btn = 0; close_btn = 0;
    obstruct = 0; moving = 0; timeout = 0;
    #12;
    chk("rst_estado", 8'(estado), 8'h0);
    chk("rst_door_closed", 8'(door_closed), 8'h1);
    chk("rst_motors", 8'({motor_open, motor_close}), 8'h0);
    chk("rst_buzzer", 8'(buzzer), 8'h0);
    rst_n = 1'b1;
    tick();

    // Full open stroke
    arrive = 1'b1;
    tick();
    arrive = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("opening_estado", 8'(estado), 8'h2);
      chk("opening_motor", 8'({motor_open, motor_close}), 8'h2);
      chk("opening_cnt", 8'(dut.cnt), 8'(i));
      tick();
    end
    chk("open_reached", 8'(estado), 8'h1);

    // Full close stroke on timeout
    timeout = 1'b1;
    tick();
    timeout = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("closing_estado", 8'(estado), 8'h3);
      chk("closing_motor", 8'({motor_open, motor_close}), 8'h1);
      tick();
    end
    chk("closed_estado", 8'(estado), 8'h0);
    chk("closed_door_closed", 8'(door_closed), 8'h1);

    // Obstruction on third closing cycle reverses from counter 2 to 5
    open_door();
    chk("reopen_open", 8'(estado), 8'h1);
    timeout = 1'b1;
    tick();
    timeout = 1'b0;
    tick();
    tick();
    chk("rev_cnt_before", 8'(dut.cnt), 8'h2);
    obstruct = 1'b1;
    tick();
    obstruct = 1'b0;
    chk("rev_estado", 8'(estado), 8'h2);
    chk("rev_cnt", 8'(dut.cnt), 8'h5);
    chk("rev_reopen_cnt", 8'(dut.reopen_cnt), 8'h1);
    tick();
    tick();
    chk("rev_still_opening", 8'(estado), 8'h2);
    tick();
    chk("rev_open_after3", 8'(estado), 8'h1);

    // Completing a close clears reopen count
    timeout = 1'b1;
    tick();
    timeout = 1'b0;
    repeat (8) tick();
    chk("close2_estado", 8'(estado), 8'h0);
    chk("close2_reopen_clr", 8'(dut.reopen_cnt), 8'h0);

    // Obstruction on four successive close attempts
    open_door();
    for (int k = 0; k < 4; k++) begin
      obstruct = 1'b0;
      timeout  = 1'b1;
      tick();
      timeout  = 1'b0;
      obstruct = 1'b1;
      chk("att_closing", 8'(estado), 8'h3);
      chk("att_buzzer", 8'(buzzer), 8'((NUDGE && k == 3) ? 1 : 0));
      if (NUDGE && k == 3) begin
        for (int i = 0; i < 8; i++) begin
          chk("nudge_estado", 8'(estado), 8'h3);
          chk("nudge_buzzer", 8'(buzzer), 8'h1);
          tick();
        end
        chk("nudge_closed", 8'(estado), 8'h0);
      end else begin
        tick();
        chk("att_reverse", 8'(estado), 8'h2);
        chk("att_reopen_cnt", 8'(dut.reopen_cnt), 8'((k + 1 > 3) ? 3 : k + 1));
        tick();
        chk("att_open", 8'(estado), 8'h1);
      end
    end
    obstruct = 1'b0;

    rst_n = 1'b0;
    #2;
    chk("rst2_estado", 8'(estado), 8'h0);
    chk("rst2_reopen", 8'(dut.reopen_cnt), 8'h0);
    rst_n = 1'b1;
    tick();

    // moving inhibits opening
    moving = 1'b1; open_btn = 1'b1; arrive = 1'b1;
    tick();
    tick();
    chk("moving_hold", 8'(estado), 8'h0);
    chk("moving_door_closed", 8'(door_closed), 8'h1);
    moving = 1'b0; open_btn = 1'b0; arrive = 1'b0;
    open_door();
    chk("open3", 8'(estado), 8'h1);

    // Simultaneous input priorities in OPEN
    timeout = 1'b1; obstruct = 1'b1;
    tick();
    chk("to_obstruct_hold", 8'(estado), 8'h1);
    timeout = 1'b0; obstruct = 1'b0; close_btn = 1'b1; open_btn = 1'b1;
    tick();
    chk("openbtn_wins", 8'(estado), 8'h1);
    open_btn = 1'b0;
    tick();
    close_btn = 1'b0;
    chk("closebtn_close", 8'(estado), 8'h3);
    tick();
    open_btn = 1'b1;
    tick();
    open_btn = 1'b0;
    chk("btn_rev_estado", 8'(estado), 8'h2);
    chk("btn_rev_cnt", 8'(dut.cnt), 8'h6);
    chk("btn_rev_no_count", 8'(dut.reopen_cnt), 8'h0);
    tick();
    tick();
    chk("btn_rev_open", 8'(estado), 8'h1);
    chk("open_motors_off", 8'({motor_open, motor_close}), 8'h0);

    // Asynchronous reset mid-close
    timeout = 1'b1;
    tick();
    timeout = 1'b0;
    tick();
    tick();
    chk("mid_close", 8'(estado), 8'h3);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_estado", 8'(estado), 8'h0);
    chk("async_rst_motor", 8'({motor_open, motor_close}), 8'h0);
    chk("async_rst_cnt", 8'(dut.cnt), 8'h0);
    #1 rst_n = 1'b1;
    tick();
    chk("post_rst_estado", 8'(estado), 8'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
